// File: rtl/adc_frame_emulator.sv
// adc_frame_emulator
//
// Delta-sigma ADC frame transmitter, clocked by the ADC data clock (dclk).
// Once per output-data period it raises drdy for one cycle, then shifts a
// READ_DCLKS-bit word out on dout, MSB first. Every output is launched on a
// rising edge, so a receiver sampling on the falling edge has half a period of
// margin. A toggle on sync_tog (clk_ctrl domain) aborts any frame in progress
// and restarts the re-settling blackout. While skip_drdy is high at the frame
// boundary, that period's frame is dropped, which lets a hub's missed-sample
// and realign paths be exercised.
//
// Ports
//   dclk          in   ADC data clock, all flops on posedge
//   rst_dclk      in   asynchronous active-high reset
//   sync_tog      in   sync request, one request per transition
//   skip_drdy     in   level, suppresses the frame starting at pos 0
//   pattern_en    in   transmit frame_cnt instead of sample_data
//   sample_data   in   [READ_DCLKS] next sample word
//   sample_valid  in   sample_data holds a fresh word
//   sample_ready  out  high in the drdy cycle of transmitted frames
//   drdy          out  one-cycle data-ready strobe
//   dout          out  serial data, MSB first
//   settling      out  re-settling blackout in progress
//   frame_cnt     out  [16] frames transmitted, wraps
//   underrun_cnt  out  [8] frames sent without a fresh sample, saturates
//
// States (describe the cycle currently presented on the outputs)
//   ST_SETTLE | blackout counter nonzero, outputs held low
//   ST_IDLE   | inter-frame gap, waiting for pos 0
//   ST_DRDY   | pos 0 of an enabled frame, drdy and sample_ready high
//   ST_SHIFT  | pos 1..READ_DCLKS, dout carries word[READ_DCLKS-pos]

module adc_frame_emulator #(
    parameter int READ_DCLKS    = 24,
    parameter int ODR_DCLKS     = 128,
    parameter int SETTLE_FRAMES = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                  dclk,
    input  logic                  rst_dclk,
    input  logic                  sync_tog,
    input  logic                  skip_drdy,
    input  logic                  pattern_en,
    input  logic [READ_DCLKS-1:0] sample_data,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  drdy,
    output logic                  dout,
    output logic                  settling,
    output logic [15:0]           frame_cnt,
    output logic [7:0]            underrun_cnt
);

    localparam int PW = $clog2(ODR_DCLKS);
    localparam int SW = $clog2(SETTLE_FRAMES + 1);
    localparam int IW = (READ_DCLKS > 1) ? $clog2(READ_DCLKS) : 1;

    typedef enum logic [1:0] {
        ST_SETTLE,
        ST_IDLE,
        ST_DRDY,
        ST_SHIFT
    } state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           pos_q, pos_d;
    logic [SW-1:0]           settle_q, settle_d;
    logic [READ_DCLKS-1:0]   word_q, word_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;
    logic [7:0]              underrun_q, underrun_d;
    logic                    drdy_q, drdy_d;
    logic                    sready_q, sready_d;
    logic                    dout_q, dout_d;
    logic                    settling_q, settling_d;
    logic [SYNC_STAGES-1:0]  sync_ff_q, sync_ff_d;
    logic                    sync_prev_q, sync_prev_d;

    logic                    sync_edge;
    logic                    pos_wrap;
    logic                    frame_go;
    logic                    in_shift;
    logic                    no_fresh;
    logic [READ_DCLKS-1:0]   word_sel;
    logic [READ_DCLKS-1:0]   shift_word;
    logic [IW-1:0]           bit_idx;

    // pos_q is the position of the cycle the next edge launches onto the
    // outputs, so every output decision is a registered function of pos_q.
    always_comb begin
        sync_ff_d[0] = sync_tog;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_ff_d[i] = sync_ff_q[i-1];
        end
        sync_prev_d = sync_ff_q[SYNC_STAGES-1];
        sync_edge   = sync_ff_q[SYNC_STAGES-1] ^ sync_prev_q;

        pos_wrap = (pos_q == PW'(ODR_DCLKS - 1));
        frame_go = (pos_q == '0) && (settle_q == '0) && !skip_drdy;
        in_shift = (state_q == ST_DRDY) ||
                   ((state_q == ST_SHIFT) && (pos_q <= PW'(READ_DCLKS)));

        // Word handed over at the edge that ends the drdy cycle.
        no_fresh = 1'b0;
        if (pattern_en) begin
            word_sel = READ_DCLKS'(frame_cnt_q);
        end else if (sample_valid) begin
            word_sel = sample_data;
        end else begin
            word_sel = word_q;
            no_fresh = 1'b1;
        end

        // The MSB goes out on the same edge that captures the word.
        shift_word = (state_q == ST_DRDY) ? word_sel : word_q;
        bit_idx    = IW'(READ_DCLKS - int'(pos_q));

        pos_d       = pos_wrap ? '0 : pos_q + PW'(1);
        settle_d    = (pos_wrap && (settle_q != '0)) ? settle_q - SW'(1) : settle_q;
        word_d      = word_q;
        frame_cnt_d = frame_cnt_q;
        underrun_d  = underrun_q;
        drdy_d      = 1'b0;
        sready_d    = 1'b0;
        dout_d      = 1'b0;
        settling_d  = (settle_q != '0);
        state_d     = (settle_q != '0) ? ST_SETTLE : ST_IDLE;

        if (sync_edge) begin
            // The abort cycle itself becomes pos 0 of the new timeline, so the
            // next edge launches pos 1.
            pos_d      = PW'(1);
            settle_d   = SW'(SETTLE_FRAMES);
            settling_d = 1'b1;
            state_d    = ST_SETTLE;
        end else begin
            if (state_q == ST_DRDY) begin
                word_d      = word_sel;
                frame_cnt_d = frame_cnt_q + 16'd1;
                if (no_fresh && (underrun_q != 8'hFF)) begin
                    underrun_d = underrun_q + 8'd1;
                end
            end
            if (frame_go) begin
                state_d  = ST_DRDY;
                drdy_d   = 1'b1;
                sready_d = 1'b1;
            end else if (in_shift) begin
                state_d = ST_SHIFT;
                dout_d  = shift_word[bit_idx];
            end
        end
    end

    always_ff @(posedge dclk or posedge rst_dclk) begin
        if (rst_dclk) begin
            state_q     <= ST_SETTLE;
            pos_q       <= '0;
            settle_q    <= SW'(SETTLE_FRAMES);
            word_q      <= '0;
            frame_cnt_q <= '0;
            underrun_q  <= '0;
            drdy_q      <= 1'b0;
            sready_q    <= 1'b0;
            dout_q      <= 1'b0;
            settling_q  <= 1'b1;
            sync_ff_q   <= '0;
            sync_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            settle_q    <= settle_d;
            word_q      <= word_d;
            frame_cnt_q <= frame_cnt_d;
            underrun_q  <= underrun_d;
            drdy_q      <= drdy_d;
            sready_q    <= sready_d;
            dout_q      <= dout_d;
            settling_q  <= settling_d;
            sync_ff_q   <= sync_ff_d;
            sync_prev_q <= sync_prev_d;
        end
    end

    assign drdy         = drdy_q;
    assign sample_ready = sready_q;
    assign dout         = dout_q;
    assign settling     = settling_q;
    assign frame_cnt    = frame_cnt_q;
    assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_adc_frame_emulator.sv
// Bench for adc_frame_emulator with SETTLE_FRAMES=2, other parameters default.
module tb_adc_frame_emulator;
    localparam int RD  = 24;
    localparam int ODR = 128;
    localparam int SF  = 2;
    localparam int SS  = 2;

    logic          dclk = 1'b0;
    logic          rst_dclk = 1'b1;
    logic          sync_tog = 1'b0;
    logic          skip_drdy = 1'b0;
    logic          pattern_en = 1'b0;
    logic [RD-1:0] sample_data = '0;
    logic          sample_valid = 1'b0;
    logic          sample_ready, drdy, dout, settling;
    logic [15:0]   frame_cnt;
    logic [7:0]    underrun_cnt;

    adc_frame_emulator #(
        .READ_DCLKS(RD), .ODR_DCLKS(ODR), .SETTLE_FRAMES(SF), .SYNC_STAGES(SS)
    ) dut (
        .dclk(dclk), .rst_dclk(rst_dclk), .sync_tog(sync_tog),
        .skip_drdy(skip_drdy), .pattern_en(pattern_en),
        .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .drdy(drdy), .dout(dout),
        .settling(settling), .frame_cnt(frame_cnt), .underrun_cnt(underrun_cnt)
    );

    always #5 dclk = ~dclk;

    // cyc = index of the most recent posedge since reset release (first = 0).
    int cyc = -1;
    always @(posedge dclk) begin
        if (rst_dclk) cyc <= -1;
        else          cyc <= cyc + 1;
    end

    typedef struct {
        int          cyc;
        logic [23:0] word;
        int          nbits;
        logic [15:0] fcnt;
        logic [7:0]  urun;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    logic [15:0] m_fcnt;
    logic [7:0]  m_urun;
    logic [23:0] m_last;
    int          next_d;
    int          last_d;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc < n) begin
            @(negedge dclk);
            guard++;
            if (guard > 100000) begin
                checks++;
                errors++;
                $display("FAIL wait_cyc: timed out waiting for cycle %0d", n);
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge dclk);
        rst_dclk     = 1'b1;
        sync_tog     = 1'b0;
        skip_drdy    = 1'b0;
        pattern_en   = 1'b0;
        sample_valid = 1'b0;
        repeat (3) @(negedge dclk);
        chk("rst_drdy", 32'(drdy), 32'(1'b0));
        chk("rst_dout", 32'(dout), 32'(1'b0));
        chk("rst_sample_ready", 32'(sample_ready), 32'(1'b0));
        chk("rst_settling", 32'(settling), 32'(1'b1));
        chk("rst_frame_cnt", 32'(frame_cnt), 32'(16'h0));
        chk("rst_underrun", 32'(underrun_cnt), 32'(8'h0));
        m_fcnt = '0;
        m_urun = '0;
        m_last = '0;
        sbq.delete();
        next_d = SF * ODR;
        last_d = next_d;
        rst_dclk = 1'b0;
    endtask

    // One output-data period: apply inputs ahead of the frame boundary and
    // predict what the frame carries, if anything.
    task automatic do_period(input bit skip, input bit pat, input bit valid,
                             input logic [23:0] data, input int nb);
        int d;
        logic [23:0] w;
        exp_t e;
        d = next_d;
        wait_cyc(d - 4);
        skip_drdy    = skip;
        pattern_en   = pat;
        sample_valid = valid;
        sample_data  = data;
        if (!skip) begin
            if (pat)        w = {8'h00, m_fcnt};
            else if (valid) w = data;
            else begin
                w = m_last;
                if (m_urun != 8'hFF) m_urun = m_urun + 8'd1;
            end
            m_fcnt = m_fcnt + 16'd1;
            m_last = w;
            e.cyc   = d;
            e.word  = w;
            e.nbits = nb;
            e.fcnt  = m_fcnt;
            e.urun  = m_urun;
            sbq.push_back(e);
        end
        last_d = d;
        next_d = d + ODR;
    endtask

    // Monitor: every drdy must match the next scoreboard entry.
    initial begin
        exp_t e;
        logic [23:0] got;
        logic [23:0] mask;
        forever begin
            @(negedge dclk);
            if (!rst_dclk) begin
                if (drdy) begin
                    chk("sample_ready_drdy", 32'(sample_ready), 32'(1'b1));
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_drdy: got drdy=1 expected none at cycle %0d", cyc);
                    end else begin
                        e = sbq.pop_front();
                        chk("drdy_cycle", 32'(cyc), 32'(e.cyc));
                        got = '0;
                        for (int b = 0; b < RD; b++) begin
                            @(negedge dclk);
                            if (b == 0) chk("drdy_width", 32'(drdy), 32'(1'b0));
                            chk("sample_ready_shift", 32'(sample_ready), 32'(1'b0));
                            got = {got[22:0], dout};
                        end
                        mask = 24'hFFFFFF << (RD - e.nbits);
                        chk("frame_word", 32'(got), 32'(e.word & mask));
                        chk("frame_cnt", 32'(frame_cnt), 32'(e.fcnt));
                        chk("underrun_cnt", 32'(underrun_cnt), 32'(e.urun));
                    end
                end else begin
                    chk("sample_ready_idle", 32'(sample_ready), 32'(1'b0));
                    chk("dout_idle", 32'(dout), 32'(1'b0));
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        do_reset();

        // First frame at cycle 256, settling drops on the same edge.
        do_period(0, 0, 1, 24'hA5C3F0, 24);
        wait_cyc(255);
        chk("settling_before", 32'(settling), 32'(1'b1));
        wait_cyc(256);
        chk("settling_after", 32'(settling), 32'(1'b0));
        do_period(0, 0, 1, 24'hA5C3F0, 24);
        do_period(0, 0, 1, 24'hA5C3F0, 24);

        // Underruns repeat the last word.
        do_period(0, 0, 1, 24'h123456, 24);
        for (int i = 0; i < 3; i++) do_period(0, 0, 0, 24'($urandom), 24);
        wait_cyc(last_d + 2);
        chk("underrun_three", 32'(underrun_cnt), 32'(8'd3));

        // Skipped period: no frame, counter unchanged, next one on schedule.
        do_period(1, 0, 1, 24'($urandom), 24);
        wait_cyc(last_d + 2);
        chk("skip_frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
        do_period(0, 0, 1, 24'($urandom), 24);

        // Randomized periods.
        for (int i = 0; i < 12; i++) begin
            do_period($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
                      1'($urandom_range(0, 1)), 24'($urandom), 24);
        end

        // Sync toggled during bit 10: bits from pos 13 on are zero.
        do_period(0, 0, 1, 24'($urandom), 12);
        d = last_d;
        wait_cyc(d + 10);
        sync_tog = ~sync_tog;
        wait_cyc(d + 13);
        chk("abort_dout", 32'(dout), 32'(1'b0));
        chk("abort_settling", 32'(settling), 32'(1'b1));
        next_d = d + 13 + SF * ODR;
        do_period(0, 0, 1, 24'($urandom), 24);
        do_period(0, 0, 1, 24'($urandom), 24);
        wait_cyc(last_d + 40);

        // Pattern mode after a fresh reset: words 0,1,2,3.
        do_reset();
        for (int i = 0; i < 4; i++) do_period(0, 1, 1'($urandom_range(0, 1)), 24'($urandom), 24);

        // Saturating underrun counter.
        for (int i = 0; i < 300; i++) do_period(0, 0, 0, 24'($urandom), 24);
        wait_cyc(last_d + 40);
        chk("underrun_saturated", 32'(underrun_cnt), 32'(8'hFF));
        chk("scoreboard_empty", 32'(sbq.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
